// File: rtl/mem_access_if.sv
// Byte-wide data-memory port of the memory stage.
// Master issues byte beats, slave accepts them and returns read bytes.
interface mem_access_if #(
  parameter int ADDR_W = 64
);
  logic              valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wbyte;
  logic [7:0]        rbyte;
  logic              ready;

  modport master (
    output valid, we, addr, wbyte,
    input  rbyte, ready
  );

  modport slave (
    input  valid, we, addr, wbyte,
    output rbyte, ready
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: serialises 8- or 1-byte loads/stores
// into byte beats and stalls the pipeline until the access completes.
module mem_access_unit #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic              req_re,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_size,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  mem_access_if.master      mem
);

  localparam int NB = DATA_W / 8;
  localparam int CW = $clog2(NB);
  localparam logic [3:0] MAXSZ = 4'(NB);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     last;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wsh;
  logic              act;
  logic              bad;
  logic              hs;

  assign act   = req_valid & (req_re | req_we);
  assign bad   = (req_re & req_we) |
                 ~((req_size == 4'd1) | (req_size == MAXSZ));
  assign hs    = mem.valid & mem.ready;
  assign wsh   = wdata_q >> 8;
  assign stall = act & ~done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= '0;
      wdata_q   <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem.valid <= 1'b0;
      mem.we    <= 1'b0;
      mem.addr  <= '0;
      mem.wbyte <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            act & bad: begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
            act & ~bad: begin
              state     <= ACCESS;
              cnt       <= '0;
              last      <= (req_size == 4'd1) ? '0 : '1;
              wdata_q   <= req_wdata;
              mem.valid <= 1'b1;
              mem.we    <= req_we;
              mem.addr  <= req_addr;
              mem.wbyte <= req_wdata[7:0];
              if (req_re)
                rdata <= '0;
            end
            default: ;
          endcase
        end
        ACCESS: begin
          if (hs) begin
            if (!mem.we)
              rdata[{cnt, 3'b000} +: 8] <= mem.rbyte;
            if (cnt == last) begin
              state     <= DONE;
              done      <= 1'b1;
              mem.valid <= 1'b0;
              mem.we    <= 1'b0;
            end else begin
              cnt       <= cnt + CW'(1);
              mem.addr  <= mem.addr + ADDR_W'(1);
              wdata_q   <= wsh;
              mem.wbyte <= wsh[7:0];
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected beats and results
// are queued at request time and popped as the DUT produces them.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic        req_re;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_size;
  logic        stall;
  logic        done;
  logic [63:0] rdata;
  logic        err;

  logic [63:0] rimg;
  logic [63:0] rbase;
  logic [63:0] off;
  logic [63:0] last_rdata;
  int          vectors;
  int          errors;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  wbyte;
  } beat_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } res_t;

  beat_t bq[$];
  res_t  rq[$];

  mem_access_if #(.ADDR_W(64)) mif ();

  mem_access_unit #(
    .ADDR_W(64),
    .DATA_W(64)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_we   (req_we),
    .req_re   (req_re),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_size (req_size),
    .stall    (stall),
    .done     (done),
    .rdata    (rdata),
    .err      (err),
    .mem      (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory image: byte i of rimg lives at rbase + i
  always_comb begin
    off       = mif.addr - rbase;
    mif.rbyte = rimg[{off[2:0], 3'b000} +: 8];
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic        we,
                        input logic        re,
                        input logic [63:0] addr,
                        input logic [63:0] wdata,
                        input logic [3:0]  size,
                        input bit          alt,
                        input logic [63:0] img,
                        input int          lat,
                        input bit          legal);
    int    n;
    bit    seen;
    beat_t b;
    res_t  r;
    rimg      = img;
    rbase     = addr;
    req_we    = we;
    req_re    = re;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    req_valid = 1'b1;
    mif.ready = 1'b1;
    n = legal ? int'(size) : 0;
    for (int i = 0; i < n; i++)
      bq.push_back('{we, addr + 64'(i), wdata[8*i +: 8]});
    if (legal && re)
      last_rdata = (size == 4'd1) ? {56'h0, img[7:0]} : img;
    rq.push_back('{last_rdata, !legal});
    seen = 0;
    for (int k = 0; k <= 40 && !seen; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
        mif.ready = alt ? logic'(k % 2 == 0) : 1'b1;
      end
      @(negedge clk);
      check("stall", 64'(stall), 64'(k != lat));
      if (mif.valid) begin
        if (bq.size() == 0)
          check("beat_extra", 64'(1), 64'(0));
        else if (mif.ready) begin
          b = bq.pop_front();
          check("beat_addr", mif.addr, b.addr);
          check("beat_we", 64'(mif.we), 64'(b.we));
          if (b.we)
            check("beat_wbyte", 64'(mif.wbyte), 64'(b.wbyte));
        end else
          check("addr_hold", mif.addr, bq[0].addr);
      end
      if (done) begin
        seen = 1;
        check("latency", 64'(k), 64'(lat));
        r = rq.pop_front();
        check("rdata", rdata, r.rdata);
        check("err", 64'(err), 64'(r.err));
      end
    end
    if (!seen)
      check("timeout", 64'(0), 64'(1));
    check("beats_left", 64'(bq.size()), 64'(0));
    bq.delete();
    rq.delete();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_re    = 1'b0;
    mif.ready = 1'b1;
  endtask

  initial begin
    vectors    = 0;
    errors     = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_re     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_size   = 4'd8;
    rimg       = '0;
    rbase      = '0;
    last_rdata = '0;
    mif.ready  = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(mif.valid), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_rdata", rdata, 64'(0));
    check("rst_addr", mif.addr, 64'(0));
    check("rst_wbyte", 64'(mif.wbyte), 64'(0));
    check("rst_we", 64'(mif.we), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_req(1'b1, 1'b0, 64'h100, 64'h8877665544332211, 4'd8,
           1'b0, 64'h0, 9, 1'b1);
    do_req(1'b0, 1'b1, 64'h20, 64'h0, 4'd1,
           1'b0, 64'hDEADBEEFCAFE55AB, 2, 1'b1);
    do_req(1'b0, 1'b1, 64'h40, 64'h0, 4'd8,
           1'b1, 64'h0807060504030201, 17, 1'b1);
    do_req(1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFC, 64'h0, 4'd8,
           1'b0, 64'h1122334455667788, 9, 1'b1);
    do_req(1'b1, 1'b0, 64'h200, 64'hFFEEDDCCBBAA9988, 4'd8,
           1'b1, 64'h0, 17, 1'b1);
    do_req(1'b0, 1'b1, 64'h80, 64'h0, 4'd4,
           1'b0, 64'h0, 1, 1'b0);
    do_req(1'b1, 1'b1, 64'h80, 64'h0, 4'd8,
           1'b0, 64'h0, 1, 1'b0);

    req_valid = 1'b1;
    req_re    = 1'b0;
    req_we    = 1'b0;
    req_size  = 4'd8;
    repeat (4) begin
      @(negedge clk);
      check("noop_stall", 64'(stall), 64'(0));
      check("noop_done", 64'(done), 64'(0));
      check("noop_valid", 64'(mif.valid), 64'(0));
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;

    // abandon an 8-byte load during its third beat
    rimg      = 64'hA8A7A6A5A4A3A2A1;
    rbase     = 64'h300;
    req_addr  = 64'h300;
    req_size  = 4'd8;
    req_re    = 1'b1;
    req_valid = 1'b1;
    mif.ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("mid_valid", 64'(mif.valid), 64'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rmid_valid", 64'(mif.valid), 64'(0));
    check("rmid_done", 64'(done), 64'(0));
    check("rmid_rdata", rdata, 64'(0));
    check("rmid_stall", 64'(stall),
          64'(req_valid & (req_re | req_we)));
    reset     = 1'b0;
    req_valid = 1'b0;
    req_re    = 1'b0;
    last_rdata = '0;
    @(posedge clk);
    #1;
    check("post_valid", 64'(mif.valid), 64'(0));

    do_req(1'b1, 1'b0, 64'h7FF, 64'h00000000000000C3, 4'd1,
           1'b1, 64'h0, 3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
